// File: rtl/lcd_frame_streamer.sv
// Two-line character frame buffer that periodically streams its whole image to the HD44780 driver
// as a set-address command followed by that line's characters, one req/ack handshake per byte.
module lcd_frame_streamer #(
    parameter int          CHARS_PER_LINE = 16,
    parameter int          REFRESH_DIV    = 1000,
    parameter logic [7:0]  BLANK          = 8'h20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic                              wr_line,
    input  logic [$clog2(CHARS_PER_LINE)-1:0] wr_col,
    input  logic [7:0]                        wr_data,
    input  logic                              clear,
    output logic                              drv_req,
    output logic                              drv_rs,
    output logic [7:0]                        drv_data,
    input  logic                              drv_ack,
    output logic                              busy,
    output logic                              frame_done
);
    localparam int CW = $clog2(CHARS_PER_LINE);
    localparam int TW = $clog2(REFRESH_DIV);

    typedef enum logic [2:0] {IDLE, ADDR0, LINE0, ADDR1, LINE1, DONE} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [0:1][0:CHARS_PER_LINE-1];
    logic [TW-1:0]   cnt;
    logic            tick;
    logic            pending, pending_n;
    logic [CW-1:0]   col, col_n;
    logic            req_n, rs_n;
    logic [7:0]      data_n;
    logic            rd_line;
    logic [7:0]      rd_byte;
    logic            last_col;
    logic            done_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 2; l++)
                for (int c = 0; c < CHARS_PER_LINE; c++)
                    mem[l][c] <= BLANK;
        end else if (clear) begin
            for (int l = 0; l < 2; l++)
                for (int c = 0; c < CHARS_PER_LINE; c++)
                    mem[l][c] <= BLANK;
        end else if (wr_en) begin
            mem[wr_line][wr_col] <= wr_data;
        end
    end

    assign tick = (cnt == TW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // A same-cycle write or clear is forwarded so the byte launched at this edge already reflects it.
    always_comb begin
        rd_line = (state == LINE1);
        rd_byte = mem[rd_line][col];
        if (clear)
            rd_byte = BLANK;
        else if (wr_en && (wr_line == rd_line) && (wr_col == col))
            rd_byte = wr_data;
    end

    assign last_col = (col == CW'(CHARS_PER_LINE - 1));
    assign done_hs  = drv_req && drv_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            col      <= '0;
            pending  <= 1'b0;
            drv_req  <= 1'b0;
            drv_rs   <= 1'b0;
            drv_data <= 8'h00;
        end else begin
            state    <= state_n;
            col      <= col_n;
            pending  <= pending_n;
            drv_req  <= req_n;
            drv_rs   <= rs_n;
            drv_data <= data_n;
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = col;
        req_n     = drv_req;
        rs_n      = drv_rs;
        data_n    = drv_data;
        pending_n = pending;
        if (tick && state != IDLE)
            pending_n = 1'b1;
        case (state)
            IDLE: begin
                if (tick || pending) begin
                    state_n   = ADDR0;
                    pending_n = 1'b0;
                    req_n     = 1'b1;
                    rs_n      = 1'b0;
                    data_n    = 8'h80;
                end
            end
            ADDR0, ADDR1: begin
                if (!drv_req) begin
                    req_n  = 1'b1;
                    rs_n   = 1'b0;
                    data_n = (state == ADDR0) ? 8'h80 : 8'hC0;
                end else if (done_hs) begin
                    req_n   = 1'b0;
                    col_n   = '0;
                    state_n = (state == ADDR0) ? LINE0 : LINE1;
                end
            end
            LINE0, LINE1: begin
                if (!drv_req) begin
                    req_n  = 1'b1;
                    rs_n   = 1'b1;
                    data_n = rd_byte;
                end else if (done_hs) begin
                    req_n = 1'b0;
                    if (last_col)
                        state_n = (state == LINE0) ? ADDR1 : DONE;
                    else
                        col_n = col + 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Randomized bench for lcd_frame_streamer: a cycle-level reference model of the frame schedule,
// handshake and buffer contents checks every output on every falling edge.
module tb_lcd_frame_streamer;
    localparam int         N  = 16;
    localparam int         RD = 64;
    localparam logic [7:0] BL = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_line = 1'b0;
    logic [3:0] wr_col = '0;
    logic [7:0] wr_data = '0;
    logic       clear = 1'b0;
    logic       drv_ack = 1'b0;
    logic       drv_req, drv_rs, busy, frame_done;
    logic [7:0] drv_data;

    int checks = 0;
    int errors = 0;
    int ack_dly = 3;     // negative: ack tied high
    int frames = 0;

    always #5 clk = ~clk;

    lcd_frame_streamer #(.CHARS_PER_LINE(N), .REFRESH_DIV(RD), .BLANK(BL)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
        .wr_data(wr_data), .clear(clear), .drv_req(drv_req), .drv_rs(drv_rs),
        .drv_data(drv_data), .drv_ack(drv_ack), .busy(busy), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected text image as seen by the display.
    logic [7:0] img [2][N];
    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            for (int l = 0; l < 2; l++)
                for (int c = 0; c < N; c++)
                    img[l][c] = BL;
        end else if (wr_en) begin
            img[wr_line][wr_col] = wr_data;
        end
    end

    // Byte k of a frame: 80, line 0 text, C0, line 1 text.
    function automatic logic [8:0] frame_byte(input int k);
        if (k == 0)          return {1'b0, 8'h80};
        else if (k <= N)     return {1'b1, img[0][k-1]};
        else if (k == N + 1) return {1'b0, 8'hC0};
        else                 return {1'b1, img[1][k-N-2]};
    endfunction

    initial begin
        int   n, pos, wcnt;
        bit   req_m, busy_m, done_m, pend_m, req_prev, tick;
        bit   nreq, nbusy, ndone;
        logic [8:0] held;
        n = 0; pos = 0; wcnt = 0; held = '0;
        req_m = 0; busy_m = 0; done_m = 0; pend_m = 0; req_prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", {drv_req, drv_rs, drv_data, busy, frame_done}, 32'h0);
                n = 0; pos = 0; wcnt = 0;
                req_m = 0; busy_m = 0; done_m = 0; pend_m = 0; req_prev = 0;
            end else begin
                chk("req", drv_req, req_m);
                chk("busy", busy, busy_m);
                chk("frame_done", frame_done, done_m);
                if (req_m) begin
                    if (!req_prev) held = frame_byte(pos);
                    chk($sformatf("byte%0d", pos), {drv_rs, drv_data}, held);
                end
                if (done_m) frames++;

                if (ack_dly < 0) drv_ack = 1'b1;
                else if (req_m) begin
                    drv_ack = (wcnt >= ack_dly);
                    wcnt++;
                end else begin
                    wcnt = 0;
                    drv_ack = 1'($urandom_range(0, 1));
                end

                tick = ((n % RD) == RD - 1);
                req_prev = req_m;
                nreq = req_m; nbusy = busy_m; ndone = 0;
                if (!busy_m) begin
                    if (tick || pend_m) begin
                        nreq = 1; nbusy = 1; pos = 0; pend_m = 0;
                    end
                end else begin
                    if (tick) pend_m = 1;
                    if (done_m) nbusy = 0;
                    else if (req_m && drv_ack) begin
                        nreq = 0;
                        if (pos == 2 * N + 1) ndone = 1;
                        else pos++;
                    end else if (!req_m) nreq = 1;
                end
                req_m = nreq; busy_m = nbusy; done_m = ndone;
                n++;
            end
        end
    end

    task automatic wr(input logic line, input int col, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_line = line; wr_col = 4'(col); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        bit got;
        got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1;
        end
        chk("frame_done_seen", got, 1);
    endtask

    initial begin
        string s0, s1;
        bit    seen;
        s0 = "HELLO";
        s1 = "WORLD";
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        wait_done(400);

        for (int i = 0; i < 5; i++) wr(1'b0, i, s0[i]);
        for (int i = 0; i < 5; i++) wr(1'b1, 11 + i, s1[i]);
        wait_done(600);
        wait_done(600);

        ack_dly = -1;
        wait_done(200);
        repeat (8) @(negedge clk);
        wr(1'b1, 0, 8'h58);
        wr(1'b0, 0, 8'h59);
        wait_done(200);
        wait_done(200);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_line = 1'($urandom_range(0, 1));
            wr_col  = 4'($urandom_range(0, N - 1));
            wr_data = 8'($urandom_range(8'h21, 8'h7E));
            clear   = ($urandom_range(0, 60) == 0);
        end
        @(negedge clk);
        wr_en = 1'b1; clear = 1'b1; wr_line = 1'b0; wr_col = 4'd3; wr_data = 8'h41;
        @(negedge clk);
        wr_en = 1'b0; clear = 1'b0;
        wait_done(200);
        wait_done(200);

        for (int i = 0; i < 8; i++) wr(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), 8'($urandom_range(8'h30, 8'h5A)));
        ack_dly = 40;
        wait_done(3000);
        repeat (400) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_done(3000);
        wait_done(3000);

        ack_dly = 10;
        wr(1'b0, 2, 8'h5A);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (drv_req) seen = 1;
        end
        chk("req_before_reset", seen, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset_outputs", {drv_req, busy, frame_done, drv_data}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_done(800);

        chk("frames_counted_ok", (frames >= 12), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_frame_streamer.md
# lcd_frame_streamer

Character frame buffer and sequencer that feeds the HD44780 LCD driver stage. Holds a 2-line text image written by upstream logic, such as the switch/button front end. Periodically streams the whole image to the driver as a set-address command followed by that line's characters, for each line. Sits directly upstream of the LCD driver and runs on the same divided clock.

## Interface
Parameters:
- CHARS_PER_LINE, 16, characters per display line (power of two, 2..64)
- REFRESH_DIV, 1000, clk cycles between frame-refresh ticks (min 64)
- BLANK, 8'h20, fill character on reset/clear

Ports:
- clk  in  1  block clock (single clock domain)
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write one character into the buffer this cycle
- wr_line  in  1  target line (0 = top, 1 = bottom)
- wr_col  in  $clog2(CHARS_PER_LINE)  target column
- wr_data  in  8  character code
- clear  in  1  fill whole buffer with BLANK (single cycle)
- drv_req  out  1  transaction valid to driver
- drv_rs  out  1  0 = command byte, 1 = character byte
- drv_data  out  8  byte to driver
- drv_ack  in  1  driver accepted the current byte
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- Buffer: 2×CHARS_PER_LINE×8 registers. All entries reset to BLANK.
- wr_en writes buf[wr_line][wr_col] <= wr_data at the clock edge.
- clear sets every entry to BLANK at the clock edge.
- clear and wr_en in the same cycle: clear wins and the write is dropped.
- Refresh counter: free-running 0..REFRESH_DIV-1, wraps to 0. A tick is generated in the cycle the count equals REFRESH_DIV-1.
- FSM states and transitions:
  - IDLE: on tick (or pending set) -> ADDR0.
  - ADDR0: send command 8'h80 (rs=0).
  - LINE0: send buf[0][0..N-1] (rs=1).
  - ADDR1: send command 8'hC0 (rs=0).
  - LINE1: send buf[1][0..N-1] (rs=1).
  - DONE: pulse frame_done -> IDLE.
- Each send is one handshake transaction, so a frame is 2N+2 transactions (34 at default).
- Pending flag:
  - Set by a tick while the FSM is not in IDLE.
  - Cleared when a new frame starts.
  - Multiple ticks during one frame collapse into one pending flag.
- Character bytes are sampled from the buffer in the cycle drv_req rises. Later writes to an already-sent column appear in the next frame. Writes to an unsent column appear in this frame.
- clear during a frame does not abort the frame. Bytes already sent are unaffected; remaining bytes read BLANK.

## Timing
- Reset values:
  - drv_req=0, drv_rs=0, drv_data=8'h00
  - busy=0, frame_done=0
  - counter=0, pending=0, FSM=IDLE, buffer=BLANK
- Reset mid-frame aborts immediately to these values. No partial transaction completes.
- Frame start: tick (or pending) observed in IDLE at cycle t -> drv_req=1 with 8'h80, rs=0 at t+1.
- Handshake:
  - drv_req, drv_rs and drv_data are registered and stay stable while drv_req=1.
  - A transaction completes in the first cycle with drv_req=1 and drv_ack=1 (cycle a).
  - drv_req=0 at a+1.
  - The next transaction asserts drv_req at a+2.
  - Minimum 2 cycles per transaction; a continuously high ack yields one byte every 2 cycles.
  - drv_ack while drv_req=0 is ignored.
- frame_done: high for exactly one cycle at a+1 of the final (buf[1][N-1]) transaction. The FSM is in IDLE at a+2.
- busy: 1 from the first drv_req cycle through the frame_done cycle inclusive.
- Pending frame: if pending=1 at frame end, the next drv_req (8'h80) rises at frame_done cycle +2.
- Buffer writes take effect at the edge. A write in cycle c is visible to a req rising at c+1.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, buffer reads BLANK on the next frame. Release, wait REFRESH_DIV cycles -> 34 transactions: 80, 16×20, C0, 16×20.
- Pattern frame: write "HELLO" at line0 col0..4 and "WORLD" at line1 col11..15. Ack each req after 3 cycles -> exact byte/rs order; frame_done one cycle after the last ack; busy spans the frame.
- Back-to-back ack (drv_ack tied 1): req toggles every cycle, 34 bytes in 68 cycles. Mid-frame write to line1 col0 -> new char sent this frame. Mid-frame write to line0 col0 -> old char sent now, new char sent in the next frame.
- Slow driver (ack after 40 cycles, REFRESH_DIV=64): ticks during the frame set pending once -> next frame's req rises 2 cycles after frame_done, with no frame skipped or doubled.
- clear + wr_en same cycle -> buffer all BLANK. clear mid-frame -> remaining bytes 8'h20.
- Reset asserted while drv_req=1 awaiting ack -> drv_req drops without a completed transaction. After release, the first frame starts at the first tick with 8'h80.
